impulse_counter_array: RTL and testbench

//   Parametrised N-channel impulse counter with RTC-gated snapshot and serial readout.

---
 rtl/impulse_counter_array_if.sv | 16 +
 rtl/impulse_counter_array.sv | 112 +++++++++++
 tb/tb_impulse_counter_array.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/impulse_counter_array_if.sv
// impulse_counter_array_if: channel/RTC inputs and serial readout outputs of the impulse counter array.
interface impulse_counter_array_if #(
   parameter int N_CH   = 8,
   parameter int ADDR_W = 4
);
   logic [N_CH-1:0]   ch;
   logic              rtc;
   logic              serial_out;
   logic              sl_out;
   logic [ADDR_W-1:0] addr_out;
   logic              ovf_global;
   logic              ovf_rtc;
   logic              busy;
   modport master (output ch, rtc, input serial_out, sl_out, addr_out, ovf_global, ovf_rtc, busy);
   modport slave  (input ch, rtc, output serial_out, sl_out, addr_out, ovf_global, ovf_rtc, busy);
endinterface

// File: rtl/impulse_counter_array.sv
// impulse_counter_array: N-channel edge counters, RTC-gated snapshot, serial MSB-first readout.
// Define IMPCNT_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module impulse_counter_array #(
   parameter int N_CH   = 8,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 4
) (
   input logic clk,
   input logic reset,
   impulse_counter_array_if.slave bus
);
   localparam int BW = $clog2(CNT_W);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t                state;
   logic [N_CH-1:0]       ch_s1, ch_s2, ch_d, ch_edge, ovf;
   logic                  rtc_s1, rtc_s2, rtc_d, rtc_edge, snap;
   logic [CNT_W-1:0]      cnt [N_CH];
   logic [N_CH*CNT_W-1:0] shadow;
   logic [CNT_W-1:0]      shreg;
   logic [ADDR_W-1:0]     idx;
   logic [BW-1:0]         bitcnt;
   assign ch_edge  = ch_s2 & ~ch_d;
   assign rtc_edge = rtc_s2 & ~rtc_d;
   assign snap     = rtc_edge && state == IDLE;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {ch_s1, ch_s2, ch_d} <= '0;
         {rtc_s1, rtc_s2, rtc_d} <= '0;
      end else begin
         ch_s1  <= bus.ch;
         ch_s2  <= ch_s1;
         ch_d   <= ch_s2;
         rtc_s1 <= bus.rtc;
         rtc_s2 <= rtc_s1;
         rtc_d  <= rtc_s2;
      end
   end
   // An edge coinciding with the snapshot counts into the new window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
         ovf            <= '0;
         shadow         <= '0;
         bus.ovf_global <= 1'b0;
         bus.ovf_rtc    <= 1'b0;
      end else begin
         if (snap) bus.ovf_global <= |ovf;
         if (rtc_edge && state != IDLE) bus.ovf_rtc <= 1'b1;
         for (int i = 0; i < N_CH; i++) begin
            if (snap) begin
               shadow[i*CNT_W +: CNT_W] <= cnt[i];
               cnt[i] <= CNT_W'(ch_edge[i]);
               ovf[i] <= 1'b0;
            end else if (ch_edge[i]) begin
               ovf[i] <= ovf[i] | (&cnt[i]);
`ifdef IMPCNT_SATURATE_EN
               cnt[i] <= (&cnt[i]) ? cnt[i] : cnt[i] + CNT_W'(1);
`else
               cnt[i] <= cnt[i] + CNT_W'(1);
`endif
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         bitcnt         <= '0;
         shreg          <= '0;
         bus.sl_out     <= 1'b0;
         bus.serial_out <= 1'b0;
         bus.addr_out   <= '0;
         bus.busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (rtc_edge) begin
               state        <= LOAD;
               idx          <= '0;
               bus.sl_out   <= 1'b1;
               bus.addr_out <= '0;
               bus.busy     <= 1'b1;
            end
            LOAD: begin
               shreg          <= shadow[int'(idx)*CNT_W +: CNT_W] << 1;
               bus.serial_out <= shadow[int'(idx)*CNT_W + CNT_W - 1];
               bus.sl_out     <= 1'b0;
               bitcnt         <= '0;
               state          <= SHIFT;
            end
            SHIFT: if (bitcnt == BW'(CNT_W - 1)) begin
               bus.serial_out <= 1'b0;
               if (idx == ADDR_W'(N_CH - 1)) begin
                  state        <= IDLE;
                  bus.addr_out <= '0;
                  bus.busy     <= 1'b0;
               end else begin
                  state        <= LOAD;
                  idx          <= idx + ADDR_W'(1);
                  bus.addr_out <= idx + ADDR_W'(1);
                  bus.sl_out   <= 1'b1;
               end
            end else begin
               bus.serial_out <= shreg[CNT_W-1];
               shreg          <= shreg << 1;
               bitcnt         <= bitcnt + BW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_impulse_counter_array.sv
// tb_impulse_counter_array: directed stimulus with a frame scoreboard on two parameterisations.
module tb_impulse_counter_array;
   localparam int W0 = 16;
   localparam int W1 = 4;
`ifdef IMPCNT_SATURATE_EN
   localparam int T3V = 15;
`else
   localparam int T3V = 1;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   longint q0[$];
   longint q1[$];
   impulse_counter_array_if #(.N_CH(8), .ADDR_W(4)) b0();
   impulse_counter_array_if #(.N_CH(3), .ADDR_W(2)) b1();
   impulse_counter_array #(.N_CH(8), .CNT_W(W0), .ADDR_W(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
   impulse_counter_array #(.N_CH(3), .CNT_W(W1), .ADDR_W(2)) u1 (.clk(clk), .reset(reset), .bus(b1));
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: rebuild each frame from sl_out/serial_out and compare with the queue head.
   int n0 = 0, bc0 = 0, a0 = 0;
   logic [31:0] sh0;
   always @(negedge clk) begin
      if (reset) begin
         n0 = 0;
         bc0 = 0;
      end else begin
         if (b0.busy) bc0++;
         else if (bc0 > 0) begin
            chk("busy span u0", bc0, 8 * (W0 + 1));
            bc0 = 0;
         end
         if (b0.sl_out) begin
            a0 = int'(b0.addr_out);
            sh0 = 0;
            n0 = W0;
         end else if (n0 > 0) begin
            sh0 = {sh0[30:0], b0.serial_out};
            n0--;
            if (n0 == 0) begin
               if (q0.size() == 0) chk("frame u0 unexpected", q0.size(), 1);
               else chk("frame u0 {addr,val}", (longint'(a0) << 32) | sh0, q0.pop_front());
            end
         end
      end
   end
   int n1 = 0, bc1 = 0, a1 = 0;
   logic [31:0] sh1;
   always @(negedge clk) begin
      if (reset) begin
         n1 = 0;
         bc1 = 0;
      end else begin
         if (b1.busy) bc1++;
         else if (bc1 > 0) begin
            chk("busy span u1", bc1, 3 * (W1 + 1));
            bc1 = 0;
         end
         if (b1.sl_out) begin
            a1 = int'(b1.addr_out);
            sh1 = 0;
            n1 = W1;
         end else if (n1 > 0) begin
            sh1 = {sh1[30:0], b1.serial_out};
            n1--;
            if (n1 == 0) begin
               if (q1.size() == 0) chk("frame u1 unexpected", q1.size(), 1);
               else chk("frame u1 {addr,val}", (longint'(a1) << 32) | sh1, q1.pop_front());
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic set_in(input int sel, input logic [7:0] m, input logic r);
      if (sel == 0) begin
         b0.ch = m;
         b0.rtc = r;
      end else begin
         b1.ch = m[2:0];
         b1.rtc = r;
      end
   endtask
   task automatic pulse(input int sel, input logic [7:0] m, input int n);
      repeat (n) begin
         set_in(sel, m, 1'b0);
         cyc(2);
         set_in(sel, 8'h00, 1'b0);
         cyc(2);
      end
   endtask
   task automatic tick(input int sel, input logic [7:0] m);
      set_in(sel, m, 1'b1);
      cyc(2);
      set_in(sel, 8'h00, 1'b0);
      cyc(2);
   endtask
   // Expected frames: every channel 0 except c1 = v1 and c2 = v2.
   task automatic expect_frames(input int sel, input int c1, input int v1, input int c2, input int v2);
      for (int a = 0; a < (sel == 0 ? 8 : 3); a++) begin
         longint e;
         e = (longint'(a) << 32) | (a == c1 ? v1 : a == c2 ? v2 : 0);
         if (sel == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask
   task automatic wait_idle(input int sel);
      int k = 0;
      while ((sel == 0 ? b0.busy : b1.busy) && k < 3000) begin
         cyc(1);
         k++;
      end
      chk("readout finished in bound", k < 3000, 1);
      cyc(4);
   endtask

   initial begin
      set_in(0, 8'h00, 1'b0);
      set_in(1, 8'h00, 1'b0);
      cyc(3);
      chk("reset busy", b0.busy, 0);
      chk("reset sl_out", b0.sl_out, 0);
      chk("reset serial_out", b0.serial_out, 0);
      chk("reset addr_out", b0.addr_out, 0);
      chk("reset ovf_global", b0.ovf_global, 0);
      chk("reset ovf_rtc", b0.ovf_rtc, 0);
      reset = 1'b0;
      cyc(3);
      // Count and readout: ch0 five pulses, ch7 three.
      pulse(0, 8'h81, 3);
      pulse(0, 8'h01, 2);
      cyc(4);
      expect_frames(0, 0, 5, 7, 3);
      tick(0, 8'h00);
      chk("T2 busy after rtc", b0.busy, 1);
      chk("T2 ovf_global", b0.ovf_global, 0);
      wait_idle(0);
      // Edge on ch1 together with rtc belongs to the following window.
      expect_frames(0, -1, 0, -1, 0);
      tick(0, 8'h02);
      wait_idle(0);
      expect_frames(0, 1, 1, -1, 0);
      tick(0, 8'h00);
      wait_idle(0);
      // RTC during readout: flagged, no snapshot, window extends.
      pulse(0, 8'h08, 2);
      cyc(4);
      expect_frames(0, 3, 2, -1, 0);
      tick(0, 8'h00);
      pulse(0, 8'h08, 3);
      cyc(8);
      chk("T5 busy at second rtc", b0.busy, 1);
      tick(0, 8'h00);
      chk("T5 ovf_rtc set", b0.ovf_rtc, 1);
      wait_idle(0);
      pulse(0, 8'h08, 1);
      cyc(4);
      expect_frames(0, 3, 4, -1, 0);
      tick(0, 8'h00);
      wait_idle(0);
      chk("T5 ovf_rtc sticky", b0.ovf_rtc, 1);
      // Asynchronous reset in the middle of a frame.
      tick(0, 8'h00);
      cyc(5);
      chk("T1 busy before reset", b0.busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("T1 busy async", b0.busy, 0);
      chk("T1 sl_out async", b0.sl_out, 0);
      chk("T1 addr_out async", b0.addr_out, 0);
      chk("T1 ovf_rtc cleared", b0.ovf_rtc, 0);
      cyc(2);
      reset = 1'b0;
      cyc(10);
      chk("T1 idle after release", b0.busy, 0);
      // Overflow on the narrow instance: 17 pulses into a 4-bit counter.
      pulse(1, 8'h04, 17);
      cyc(4);
      expect_frames(1, 2, T3V, -1, 0);
      tick(1, 8'h00);
      chk("T3 ovf_global set", b1.ovf_global, 1);
      wait_idle(1);
      pulse(1, 8'h04, 1);
      cyc(4);
      expect_frames(1, 2, 1, -1, 0);
      tick(1, 8'h00);
      chk("T3 ovf_global cleared", b1.ovf_global, 0);
      wait_idle(1);
      chk("queue u0 drained", q0.size(), 0);
      chk("queue u1 drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
